class_score_sequencer: RTL and testbench

CLASS_SCORE_SEQUENCER -- requirements
Module: class_score_sequencer

---
 rtl/class_score_sequencer.sv | 236 +++++++++++++++++++++++
 tb/tb_class_score_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/class_score_sequencer.sv
// Scans a grid of cells against NUM_CLASSES weight ROMs, accumulates signed per-class scores and picks the winner.
// Define CLASS_SCORE_MARGIN_EN to add second-best tracking, margin_out and low_conf.
module class_score_sequencer #(
   parameter int NUM_CLASSES   = 4,
   parameter int NUM_CELLS     = 256,
   parameter int WEIGHT_BITS   = 8,
   parameter int CELL_BITS     = 8,
   parameter int ACC_BITS      = WEIGHT_BITS + CELL_BITS + $clog2(NUM_CELLS),
   parameter int MARGIN_THRESH = 64
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               start,
   input  logic                               abort,
   output logic [$clog2(NUM_CELLS)-1:0]       cell_addr,
   input  logic [CELL_BITS-1:0]               cell_val,
   input  logic [NUM_CLASSES*WEIGHT_BITS-1:0] weight_in,
   output logic                               busy,
   output logic                               done,
   output logic [$clog2(NUM_CLASSES)-1:0]     class_out,
   output logic [NUM_CLASSES*ACC_BITS-1:0]    score_out,
   output logic [ACC_BITS-1:0]                margin_out,
   output logic                               low_conf
);

   localparam int AW  = $clog2(NUM_CELLS);
   localparam int CW  = $clog2(NUM_CLASSES);
   localparam int PW  = WEIGHT_BITS + CELL_BITS + 1;
   localparam int EXT = ACC_BITS - PW;
   localparam logic [AW-1:0] LAST_ADDR   = AW'(NUM_CELLS - 1);
   localparam logic [AW-1:0] ADDR_ONE    = AW'(1);
   localparam logic [AW-1:0] ADDR_ZERO   = AW'(0);
   localparam logic [CW-1:0] LAST_CLASS  = CW'(NUM_CLASSES - 1);
   localparam logic [CW-1:0] CLASS_ONE   = CW'(1);
   localparam logic [CW-1:0] FIRST_CLASS = CW'(0);
   localparam logic [ACC_BITS-1:0] ACC_ZERO = {ACC_BITS{1'b0}};

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SCAN   = 3'd1,
      S_DRAIN  = 3'd2,
      S_ARGMAX = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t                     state_q, state_d;
   logic                       busy_q, busy_d;
   logic                       done_q, done_d;
   logic                       valid_q, valid_d;
   logic [AW-1:0]              addr_q, addr_d;
   logic [CW-1:0]              idx_q, idx_d;
   logic                       start_acc_s;
   logic                       latch_s;
   logic signed [PW-1:0]       prod_s [NUM_CLASSES];
   logic signed [ACC_BITS-1:0] acc_q  [NUM_CLASSES];
   logic signed [ACC_BITS-1:0] cand_s;
   logic signed [ACC_BITS-1:0] best_q, best_d;
   logic [CW-1:0]              bidx_q, bidx_d;
   logic [CW-1:0]              class_q;
   logic [NUM_CLASSES*ACC_BITS-1:0] score_q;
   logic [ACC_BITS-1:0]        margin_q, margin_d;
   logic                       low_q, low_d;
`ifdef CLASS_SCORE_MARGIN_EN
   localparam logic signed [ACC_BITS-1:0] ACC_MIN = {1'b1, {(ACC_BITS-1){1'b0}}};
   localparam logic [ACC_BITS-1:0]        THRESH  = ACC_BITS'(MARGIN_THRESH);
   logic signed [ACC_BITS-1:0] second_q, second_d;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; abort wins over start in IDLE and cancels any running phase
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   state_d = (start && !abort) ? S_SCAN : S_IDLE;
         S_SCAN: begin
            if (abort)                    state_d = S_IDLE;
            else if (addr_q == LAST_ADDR) state_d = S_DRAIN;
            else                          state_d = S_SCAN;
         end
         S_DRAIN:  state_d = abort ? S_IDLE : S_ARGMAX;
         S_ARGMAX: begin
            if (abort)                     state_d = S_IDLE;
            else if (idx_q == LAST_CLASS)  state_d = S_DONE;
            else                           state_d = S_ARGMAX;
         end
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Output and control decode from the state transition
   always_comb begin
      start_acc_s = (state_q == S_IDLE) && (state_d == S_SCAN);
      latch_s     = (state_q == S_ARGMAX) && (state_d == S_DONE);
      busy_d      = (state_d != S_IDLE);
      done_d      = (state_d == S_DONE);
      valid_d     = (state_q == S_SCAN);
      if (start_acc_s) begin
         addr_d = ADDR_ZERO;
      end else if ((state_q == S_SCAN) && (state_d == S_SCAN)) begin
         addr_d = addr_q + ADDR_ONE;
      end else begin
         addr_d = addr_q;
      end
      if ((state_q == S_ARGMAX) && (state_d == S_ARGMAX)) begin
         idx_d = idx_q + CLASS_ONE;
      end else begin
         idx_d = FIRST_CLASS;
      end
   end

   // Control registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         addr_q  <= ADDR_ZERO;
         idx_q   <= FIRST_CLASS;
      end else begin
         busy_q  <= busy_d;
         done_q  <= done_d;
         valid_q <= valid_d;
         addr_q  <= addr_d;
         idx_q   <= idx_d;
      end
   end

   // Signed weight times zero-extended cell value, one product per class
   always_comb begin
      for (int k = 0; k < NUM_CLASSES; k++) begin
         prod_s[k] = $signed(weight_in[k*WEIGHT_BITS +: WEIGHT_BITS]) * $signed({1'b0, cell_val});
      end
   end

   // Accumulators: clear on start acceptance, add whenever the delayed valid bit is set
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_CLASSES; k++) acc_q[k] <= ACC_ZERO;
      end else if (start_acc_s) begin
         for (int k = 0; k < NUM_CLASSES; k++) acc_q[k] <= ACC_ZERO;
      end else if (valid_q) begin
         for (int k = 0; k < NUM_CLASSES; k++) begin
            acc_q[k] <= acc_q[k] + {{EXT{prod_s[k][PW-1]}}, prod_s[k]};
         end
      end
   end

   assign cand_s = acc_q[idx_q];

   // Sequential argmax step: strict greater-than keeps the lowest index on ties
   always_comb begin
      best_d = best_q;
      bidx_d = bidx_q;
`ifdef CLASS_SCORE_MARGIN_EN
      second_d = second_q;
      if (idx_q == FIRST_CLASS) begin
         best_d   = cand_s;
         bidx_d   = idx_q;
         second_d = ACC_MIN;
      end else if (cand_s > best_q) begin
         second_d = best_q;
         best_d   = cand_s;
         bidx_d   = idx_q;
      end else if (cand_s > second_q) begin
         second_d = cand_s;
      end else begin
         second_d = second_q;
      end
      margin_d = best_d - second_d;
      low_d    = (margin_d < THRESH);
`else
      if (idx_q == FIRST_CLASS) begin
         best_d = cand_s;
         bidx_d = idx_q;
      end else if (cand_s > best_q) begin
         best_d = cand_s;
         bidx_d = idx_q;
      end else begin
         best_d = best_q;
         bidx_d = bidx_q;
      end
      margin_d = ACC_ZERO;
      low_d    = 1'b0;
`endif
   end

   // Argmax running state, advanced only while in ARGMAX
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         best_q   <= ACC_ZERO;
         bidx_q   <= FIRST_CLASS;
`ifdef CLASS_SCORE_MARGIN_EN
         second_q <= ACC_ZERO;
`endif
      end else if (state_q == S_ARGMAX) begin
         best_q   <= best_d;
         bidx_q   <= bidx_d;
`ifdef CLASS_SCORE_MARGIN_EN
         second_q <= second_d;
`endif
      end
   end

   // Result registers load only on the transition into DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         class_q  <= FIRST_CLASS;
         score_q  <= {(NUM_CLASSES*ACC_BITS){1'b0}};
         margin_q <= ACC_ZERO;
         low_q    <= 1'b0;
      end else if (latch_s) begin
         class_q  <= bidx_d;
         margin_q <= margin_d;
         low_q    <= low_d;
         for (int k = 0; k < NUM_CLASSES; k++) score_q[k*ACC_BITS +: ACC_BITS] <= acc_q[k];
      end
   end

   assign cell_addr  = addr_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign class_out  = class_q;
   assign score_out  = score_q;
   assign margin_out = margin_q;
   assign low_conf   = low_q;

endmodule

// File: tb/tb_class_score_sequencer.sv
// Directed and randomized bench for class_score_sequencer; expected results come from a plain
// sum-of-products reference model over the bench's own grid and weight tables.
module tb_class_score_sequencer;

   localparam int NC   = 4;
   localparam int NCEL = 256;
   localparam int WB   = 8;
   localparam int CB   = 8;
   localparam int ACC  = 24;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               start;
   logic               abort;
   logic [7:0]         cell_addr;
   logic [CB-1:0]      cell_val;
   logic [NC*WB-1:0]   weight_in;
   logic               busy;
   logic               done;
   logic [1:0]         class_out;
   logic [NC*ACC-1:0]  score_out;
   logic [ACC-1:0]     margin_out;
   logic               low_conf;

   logic [7:0]         cell_mem [NCEL];
   logic signed [7:0]  wmem [NC][NCEL];

   int checks = 0;
   int errors = 0;

   logic [1:0]        exp_class;
   logic [NC*ACC-1:0] exp_score;
   logic [ACC-1:0]    exp_margin;
   logic              exp_low;

   class_score_sequencer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .abort      (abort),
      .cell_addr  (cell_addr),
      .cell_val   (cell_val),
      .weight_in  (weight_in),
      .busy       (busy),
      .done       (done),
      .class_out  (class_out),
      .score_out  (score_out),
      .margin_out (margin_out),
      .low_conf   (low_conf)
   );

   always #5 clk = ~clk;

   // Synchronous-read grid map and weight ROMs: data appears one cycle after the address
   always @(posedge clk) begin
      cell_val <= cell_mem[cell_addr];
      for (int k = 0; k < NC; k++) weight_in[k*WB +: WB] <= wmem[k][cell_addr];
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: score_k = sum over cells of weight_k[c] * cell[c]; winner is first maximum
   task automatic compute_model();
      longint s [NC];
      longint second;
      int     best;
      for (int k = 0; k < NC; k++) begin
         s[k] = 0;
         for (int c = 0; c < NCEL; c++) s[k] += longint'(wmem[k][c]) * longint'(cell_mem[c]);
      end
      best = 0;
      for (int k = 1; k < NC; k++) if (s[k] > s[best]) best = k;
      second = -(longint'(1) <<< 40);
      for (int k = 0; k < NC; k++) if (k != best && s[k] > second) second = s[k];
      exp_class = 2'(best);
      for (int k = 0; k < NC; k++) exp_score[k*ACC +: ACC] = s[k][ACC-1:0];
`ifdef CLASS_SCORE_MARGIN_EN
      exp_margin = ACC'(s[best] - second);
      exp_low    = ((s[best] - second) < 64);
`else
      exp_margin = '0;
      exp_low    = 1'b0;
`endif
   endtask

   task automatic check_results(input string tag);
      chk({tag, "_class"},  128'(class_out),  128'(exp_class));
      chk({tag, "_score"},  128'(score_out),  128'(exp_score));
      chk({tag, "_margin"}, 128'(margin_out), 128'(exp_margin));
      chk({tag, "_low"},    128'(low_conf),   128'(exp_low));
   endtask

   // Full inference; restart_at >= 0 re-pulses start at that many edges into the run
   task automatic run(input string tag, input int restart_at);
      int n;
      int ndone;
      compute_model();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({tag, "_busy_start"}, 128'(busy), 128'(1'b1));
      chk({tag, "_addr0"}, 128'(cell_addr), 128'(8'd0));
      n = 0;
      ndone = 0;
      while (ndone == 0 && n < 400) begin
         if (n == restart_at) start = 1'b1;
         tick();
         start = 1'b0;
         n++;
         if (n == 100) chk({tag, "_addr100"}, 128'(cell_addr), 128'(8'd100));
         if (done) ndone++;
      end
      chk({tag, "_latency"}, 128'(n), 128'(261));
      check_results(tag);
      tick();
      chk({tag, "_done_low"}, 128'(done), 128'(1'b0));
      chk({tag, "_busy_low"}, 128'(busy), 128'(1'b0));
      chk({tag, "_addr_hold"}, 128'(cell_addr), 128'(8'd255));
      for (int i = 0; i < 20; i++) begin
         tick();
         if (done) ndone++;
      end
      chk({tag, "_single_done"}, 128'(ndone), 128'(1));
   endtask

   task automatic fill_random();
      for (int c = 0; c < NCEL; c++) begin
         cell_mem[c] = 8'($urandom);
         for (int k = 0; k < NC; k++) wmem[k][c] = 8'($urandom);
      end
   endtask

   task automatic fill_const(input logic [7:0] cv);
      for (int c = 0; c < NCEL; c++) begin
         cell_mem[c] = cv;
         for (int k = 0; k < NC; k++) wmem[k][c] = 8'sd0;
      end
   endtask

   initial begin
      int n;
      int ndone;
      logic signed [7:0] wt;
      rst_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      fill_const(8'd0);
      repeat (3) tick();
      chk("rst_busy",   128'(busy),       128'(1'b0));
      chk("rst_done",   128'(done),       128'(1'b0));
      chk("rst_addr",   128'(cell_addr),  128'(8'd0));
      chk("rst_class",  128'(class_out),  128'(2'd0));
      chk("rst_score",  128'(score_out),  128'(0));
      chk("rst_margin", 128'(margin_out), 128'(0));
      chk("rst_low",    128'(low_conf),   128'(1'b0));
      rst_n = 1'b1;

      run("zeros", -1);

      fill_const(8'd0);
      cell_mem[5] = 8'd10;
      for (int c = 0; c < NCEL; c++) wmem[2][c] = 8'sd50;
      run("single", -1);

      fill_const(8'd255);
      for (int c = 0; c < NCEL; c++) wmem[0][c] = 8'sd127;
      run("maxpos", 99);
      chk("maxpos_value", 128'(score_out[ACC-1:0]), 128'(24'd8290560));

      fill_random();
      run("rand0", -1);

      fill_random();
      for (int c = 0; c < NCEL; c++) begin
         wt = 8'($urandom_range(127, 1));
         wmem[0][c] = 8'sd0;
         wmem[1][c] = wt;
         wmem[2][c] = -wt;
         wmem[3][c] = wt;
      end
      run("tie", -1);

      // Abort mid-scan: previous results must survive and no done may appear
      fill_random();
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (cell_addr != 8'd100 && n < 300) begin
         tick();
         n++;
      end
      chk("abort_reach", 128'(cell_addr), 128'(8'd100));
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_busy", 128'(busy), 128'(1'b0));
      ndone = 0;
      for (int i = 0; i < 280; i++) begin
         tick();
         if (done) ndone++;
      end
      chk("abort_no_done", 128'(ndone), 128'(0));
      check_results("abort_held");
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      chk("start_abort_idle", 128'(busy), 128'(1'b0));
      run("after_abort", -1);

      // Reset mid-scan: outputs clear asynchronously, then a fresh run completes
      fill_random();
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (cell_addr != 8'd50 && n < 300) begin
         tick();
         n++;
      end
      chk("reset_reach", 128'(cell_addr), 128'(8'd50));
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_busy",   128'(busy),       128'(1'b0));
      chk("mid_rst_addr",   128'(cell_addr),  128'(8'd0));
      chk("mid_rst_score",  128'(score_out),  128'(0));
      chk("mid_rst_class",  128'(class_out),  128'(2'd0));
      chk("mid_rst_margin", 128'(margin_out), 128'(0));
      chk("mid_rst_low",    128'(low_conf),   128'(1'b0));
      #1 rst_n = 1'b1;
      run("after_reset", -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
